mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter BYTE_LANES, default 4: data-memory byte lanes; legal values are 4 and 8.
REQ-002 SHALL have parameter WAIT_LIMIT, default 16: maximum mem_ready wait cycles per access; legal range 1..255.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port instr_rdata, input, 32: instruction word from instruction memory.
REQ-007 SHALL have port mem_ready, input, 1: memory access-complete strobe.
REQ-008 SHALL have port alu_zero, input, 1: ALU zero flag.
REQ-009 SHALL have port alu_addr_lsb, input, log2(BYTE_LANES): low address bits of the ALU result.
REQ-010 SHALL have port mem_req, output, 1: memory request.
REQ-011 SHALL have port data_mem_wren, output, BYTE_LANES: per-lane store enables.
REQ-012 SHALL have port reg_file_wren, output, 1.
REQ-013 SHALL have port reg_file_dmux_select, output, 1: 0 selects memory data, 1 selects ALU result.
REQ-014 SHALL have port reg_file_rmux_select, output, 1: 1 selects rd, 0 selects rt.
REQ-015 SHALL have port alu_mux_select, output, 1: 1 selects immediate.
REQ-016 SHALL have port alu_control, output, 4.
REQ-017 SHALL have port pc_control, output, 3.
REQ-018 SHALL have port pc_wren, output, 1.
REQ-019 SHALL have port state, output, 3: current FSM state.
REQ-020 SHALL have port mem_timeout, output, 1: one-cycle timeout pulse.
REQ-021 SHALL have port illegal_op, output, 1: sticky illegal-opcode flag.

Function
REQ-022 SHALL implement an FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-023 In FETCH, SHALL hold mem_req=1; on mem_ready SHALL capture instr_rdata into an internal IR, pulse pc_wren with pc_control=000 (PC+4), and go to DECODE.
REQ-024 DECODE SHALL last 1 cycle and SHALL drive alu_mux_select, reg_file_rmux_select and alu_control from the IR only; these outputs SHALL stay stable until the next FETCH.
REQ-025 alu_control encoding SHALL be: and/andi=0000, or/ori=0001, addu/addiu=0010, xor=0011, nor=0100, subu=0110, slt/slti=0111, sll=1000, srl=1001, sra=1010, add/addi/lw/lh/lb/sw/sh/sb=1011, sub/beq/bne=1100, all others=1111.
REQ-026 EXEC SHALL last 1 cycle and SHALL sample alu_zero at its end.
REQ-027 In EXEC, j/jal SHALL pulse pc_wren with pc_control=001, jr SHALL use 010, beq taken (alu_zero=1) and bne taken (alu_zero=0) SHALL use 011, and each of these SHALL then go to FETCH.
REQ-028 In EXEC, a not-taken branch SHALL go to FETCH without pc_wren; jal SHALL perform no register write.
REQ-029 From EXEC, loads/stores (opcodes 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B) SHALL go to MEM; all other ALU instructions SHALL go to WB.
REQ-030 In MEM, SHALL hold mem_req=1; for stores, data_mem_wren SHALL be asserted only in MEM.
REQ-031 Store lanes: sb SHALL enable lane alu_addr_lsb; sh SHALL enable 2 lanes starting at {alu_addr_lsb[msb:1],0}; sw SHALL enable 4 lanes starting at the 4-aligned lane; with BYTE_LANES=4, sw SHALL enable 1111.
REQ-032 On mem_ready in MEM, a load SHALL go to WB and a store SHALL go to FETCH.
REQ-033 A wait counter SHALL count cycles in FETCH/MEM without mem_ready and SHALL clear on each state change.
REQ-034 When the wait counter reaches WAIT_LIMIT, SHALL pulse mem_timeout for 1 cycle, drop mem_req for that cycle, and re-issue the same access (state unchanged).
REQ-035 WB SHALL last 1 cycle with reg_file_wren=1; reg_file_wren SHALL be 0 in every other state.
REQ-036 reg_file_dmux_select SHALL be 0 for loads and 1 otherwise.
REQ-037 Instruction latency: ALU op = 4 cycles + fetch wait; load = 5 + waits; store = 4 + waits; branch/jump = 3 + fetch wait.
REQ-038 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-039 On reset_n low, the FSM SHALL go to FETCH and the IR and wait counter SHALL clear asynchronously.
REQ-040 During reset, mem_req=0, data_mem_wren=0, reg_file_wren=0, pc_wren=0, reg_file_dmux_select=1, reg_file_rmux_select=0, alu_mux_select=0, alu_control=1111, pc_control=000, mem_timeout=0, illegal_op=0.
REQ-041 Reset mid-access SHALL abandon the access with no write.
REQ-042 FETCH SHALL assert mem_req from the first clock after deassertion.

Configuration
REQ-043 With MCU_ILLEGAL_TRAP_EN defined, an undecoded opcode in DECODE SHALL go to TRAP, set illegal_op=1, hold all enables at 0, and leave TRAP only on reset.
REQ-044 Without MCU_ILLEGAL_TRAP_EN, an undecoded opcode SHALL execute as a NOP (EXEC, then FETCH, no writes), TRAP SHALL be unreachable, and illegal_op SHALL be tied to 0.

Verification
REQ-045 add $3,$1,$2 (0x00221820) with mem_ready immediate -> states 0,1,2,4; alu_control=1011; rmux=1; reg_file_wren high only in WB.
REQ-046 beq (op 0x04) with alu_zero=1 -> pc_wren pulse with pc_control=011 in EXEC; with alu_zero=0 -> no EXEC pc_wren and a return to FETCH.
REQ-047 sb with alu_addr_lsb=2, BYTE_LANES=4 -> data_mem_wren=0100 in MEM only; sh with alu_addr_lsb=3 -> 1100; sw -> 1111.
REQ-048 lw with mem_ready held low 16 cycles in MEM (WAIT_LIMIT=16) -> mem_timeout pulse, mem_req low 1 cycle, then re-request; mem_ready -> WB with dmux=0.
REQ-049 Opcode 0x3F with the macro defined -> TRAP, illegal_op=1 until reset_n low; without the macro -> NOP back to FETCH, no writes.
REQ-050 reset_n low during MEM of sw -> data_mem_wren=0 immediately and state=0.

Source files
------------

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle control FSM with memory wait/timeout handling
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for a MIPS-style datapath.
// Build option MCU_ILLEGAL_TRAP_EN: undecoded opcodes enter TRAP and set the
// sticky illegal_op flag; without it they retire as NOPs.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   instr_rdata            instruction word, captured into IR on fetch handshake
//   mem_ready              access-complete strobe (used only in FETCH/MEM)
//   alu_zero, alu_addr_lsb ALU flag and low address bits, sampled at end of EXEC
//   mem_req, data_mem_wren memory request and per-lane store enables
//   reg_file_*, alu_*      datapath controls, decoded from the fetched word
//   pc_control, pc_wren    PC update select and strobe
//   state                  current FSM state
//   mem_timeout            one-cycle pulse when an access exceeds WAIT_LIMIT
//   illegal_op             sticky illegal-opcode flag (trap build only)
module mc_control_unit #(
   parameter int BYTE_LANES = 4,
   parameter int WAIT_LIMIT = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [31:0]                   instr_rdata,
   input  logic                          mem_ready,
   input  logic                          alu_zero,
   input  logic [$clog2(BYTE_LANES)-1:0] alu_addr_lsb,
   output logic                          mem_req,
   output logic [BYTE_LANES-1:0]         data_mem_wren,
   output logic                          reg_file_wren,
   output logic                          reg_file_dmux_select,
   output logic                          reg_file_rmux_select,
   output logic                          alu_mux_select,
   output logic [3:0]                    alu_control,
   output logic [2:0]                    pc_control,
   output logic                          pc_wren,
   output logic [2:0]                    state,
   output logic                          mem_timeout,
   output logic                          illegal_op
);

   localparam int LW = $clog2(BYTE_LANES);
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_LOAD, C_STORE, C_JUMP, C_JR, C_BEQ, C_BNE, C_ILL
   } cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [3:0] alu;
      logic       imm;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d.cls = C_ILL;
      d.alu = 4'b1111;
      d.imm = 1'b0;
      case (w[31:26])
         6'h00: begin
            d.cls = C_ALU;
            case (w[5:0])
               6'h00: d.alu = 4'b1000;
               6'h02: d.alu = 4'b1001;
               6'h03: d.alu = 4'b1010;
               6'h08: d.cls = C_JR;
               6'h20: d.alu = 4'b1011;
               6'h21: d.alu = 4'b0010;
               6'h22: d.alu = 4'b1100;
               6'h23: d.alu = 4'b0110;
               6'h24: d.alu = 4'b0000;
               6'h25: d.alu = 4'b0001;
               6'h26: d.alu = 4'b0011;
               6'h27: d.alu = 4'b0100;
               6'h2A: d.alu = 4'b0111;
               default: d.cls = C_ILL;
            endcase
         end
         6'h02, 6'h03: d.cls = C_JUMP;
         6'h04: begin d.cls = C_BEQ; d.alu = 4'b1100; end
         6'h05: begin d.cls = C_BNE; d.alu = 4'b1100; end
         6'h08: begin d.cls = C_ALU; d.alu = 4'b1011; d.imm = 1'b1; end
         6'h09: begin d.cls = C_ALU; d.alu = 4'b0010; d.imm = 1'b1; end
         6'h0A: begin d.cls = C_ALU; d.alu = 4'b0111; d.imm = 1'b1; end
         6'h0C: begin d.cls = C_ALU; d.alu = 4'b0000; d.imm = 1'b1; end
         6'h0D: begin d.cls = C_ALU; d.alu = 4'b0001; d.imm = 1'b1; end
         6'h20, 6'h21, 6'h23: begin d.cls = C_LOAD; d.alu = 4'b1011; d.imm = 1'b1; end
         6'h24, 6'h25: begin d.cls = C_LOAD; d.imm = 1'b1; end
         6'h28, 6'h29, 6'h2B: begin d.cls = C_STORE; d.alu = 4'b1011; d.imm = 1'b1; end
         default: ;
      endcase
      return d;
   endfunction

   // Lane enables are aligned to the access size: sh/sw clear the low address bits.
   function automatic logic [BYTE_LANES-1:0] store_lanes(input logic [5:0] op,
                                                          input logic [LW-1:0] lsb);
      logic [BYTE_LANES-1:0] l;
      l = '0;
      case (op)
         6'h28: l = BYTE_LANES'(1) << lsb;
         6'h29: l = BYTE_LANES'(3) << (lsb & ~LW'(1));
         6'h2B: l = BYTE_LANES'(15) << (lsb & ~LW'(3));
         default: ;
      endcase
      return l;
   endfunction

   state_t                cur_state;
   cls_t                  cls;
   logic [31:0]           ir;
   logic [7:0]            wait_cnt;
   logic [BYTE_LANES-1:0] st_lanes;
   logic [BYTE_LANES-1:0] lanes;
   dec_t                  dec_in;
   logic                  ir_unused;
   logic                  illegal_q;

   assign dec_in    = decode(instr_rdata);
   assign lanes     = store_lanes(ir[31:26], alu_addr_lsb);
   assign ir_unused = ^ir[25:0];
   assign state     = cur_state;

`ifdef MCU_ILLEGAL_TRAP_EN
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   // PC strobes depend on the same-cycle mem_ready (fetch) and alu_zero (branch
   // resolution at the end of EXEC), so they cannot be registered a cycle early.
   always_comb begin
      pc_wren    = 1'b0;
      pc_control = 3'b000;
      if (cur_state == S_FETCH) begin
         pc_wren = mem_req && mem_ready;
      end else if (cur_state == S_EXEC) begin
         case (cls)
            C_JUMP:  begin pc_wren = 1'b1; pc_control = 3'b001; end
            C_JR:    begin pc_wren = 1'b1; pc_control = 3'b010; end
            C_BEQ:   if (alu_zero)  begin pc_wren = 1'b1; pc_control = 3'b011; end
            C_BNE:   if (!alu_zero) begin pc_wren = 1'b1; pc_control = 3'b011; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_state            <= S_FETCH;
         cls                  <= C_ILL;
         ir                   <= '0;
         wait_cnt             <= '0;
         st_lanes             <= '0;
         mem_req              <= 1'b0;
         data_mem_wren        <= '0;
         reg_file_wren        <= 1'b0;
         reg_file_dmux_select <= 1'b1;
         reg_file_rmux_select <= 1'b0;
         alu_mux_select       <= 1'b0;
         alu_control          <= 4'b1111;
         mem_timeout          <= 1'b0;
         illegal_q            <= 1'b0;
      end else begin
         mem_timeout <= 1'b0;
         case (cur_state)
            S_FETCH, S_MEM: begin
               if (!mem_req) begin
                  // Idle cycle after reset or a timeout: (re)issue the access.
                  mem_req <= 1'b1;
                  if (cur_state == S_MEM) data_mem_wren <= st_lanes;
               end else if (mem_ready) begin
                  wait_cnt <= '0;
                  if (cur_state == S_FETCH) begin
                     ir                   <= instr_rdata;
                     cls                  <= dec_in.cls;
                     alu_control          <= dec_in.alu;
                     alu_mux_select       <= dec_in.imm;
                     reg_file_rmux_select <= (instr_rdata[31:26] == 6'h00);
                     reg_file_dmux_select <= (dec_in.cls != C_LOAD);
                     mem_req              <= 1'b0;
                     cur_state            <= S_DECODE;
                  end else begin
                     data_mem_wren <= '0;
                     if (cls == C_LOAD) begin
                        mem_req       <= 1'b0;
                        reg_file_wren <= 1'b1;
                        cur_state     <= S_WB;
                     end else begin
                        cur_state <= S_FETCH;
                     end
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  wait_cnt      <= '0;
                  mem_timeout   <= 1'b1;
                  mem_req       <= 1'b0;
                  data_mem_wren <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               cur_state <= S_EXEC;
`ifdef MCU_ILLEGAL_TRAP_EN
               if (cls == C_ILL) begin
                  cur_state <= S_TRAP;
                  illegal_q <= 1'b1;
               end
`endif
            end
            S_EXEC: begin
               st_lanes <= (cls == C_STORE) ? lanes : '0;
               case (cls)
                  C_LOAD:  begin mem_req <= 1'b1; cur_state <= S_MEM; end
                  C_STORE: begin mem_req <= 1'b1; data_mem_wren <= lanes; cur_state <= S_MEM; end
                  C_ALU:   begin reg_file_wren <= 1'b1; cur_state <= S_WB; end
                  default: begin mem_req <= 1'b1; cur_state <= S_FETCH; end
               endcase
            end
            S_WB: begin
               reg_file_wren <= 1'b0;
               mem_req       <= 1'b1;
               cur_state     <= S_FETCH;
            end
            S_TRAP: ;
            default: cur_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized self-checking bench for mc_control_unit
module tb_mc_control_unit;

   localparam int BL = 4;
   localparam int LW = 2;
   localparam int WL = 16;

   localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_J = 3, K_JR = 4, K_BEQ = 5, K_BNE = 6, K_ILL = 7;

   logic          clk;
   logic          reset_n;
   logic [31:0]   instr_rdata;
   logic          mem_ready;
   logic          alu_zero;
   logic [LW-1:0] alu_addr_lsb;
   logic          mem_req;
   logic [BL-1:0] data_mem_wren;
   logic          reg_file_wren;
   logic          reg_file_dmux_select;
   logic          reg_file_rmux_select;
   logic          alu_mux_select;
   logic [3:0]    alu_control;
   logic [2:0]    pc_control;
   logic          pc_wren;
   logic [2:0]    state;
   logic          mem_timeout;
   logic          illegal_op;

   mc_control_unit #(.BYTE_LANES(BL), .WAIT_LIMIT(WL)) dut (
      .clk(clk), .reset_n(reset_n), .instr_rdata(instr_rdata), .mem_ready(mem_ready),
      .alu_zero(alu_zero), .alu_addr_lsb(alu_addr_lsb), .mem_req(mem_req),
      .data_mem_wren(data_mem_wren), .reg_file_wren(reg_file_wren),
      .reg_file_dmux_select(reg_file_dmux_select), .reg_file_rmux_select(reg_file_rmux_select),
      .alu_mux_select(alu_mux_select), .alu_control(alu_control), .pc_control(pc_control),
      .pc_wren(pc_wren), .state(state), .mem_timeout(mem_timeout), .illegal_op(illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int op;
      int fn;
      int cls;
      int alu;
      bit imm;
   } ent_t;

   ent_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   e_cls, e_alu;
   bit   e_imm, e_rmux, e_dmux;
   logic exp_ill;
   bit   dec_chk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic add(input int op, input int fn, input int cls, input int alu, input bit imm);
      ent_t e;
      e.op = op; e.fn = fn; e.cls = cls; e.alu = alu; e.imm = imm;
      tbl.push_back(e);
   endtask

   // Instruction table lookup; fn < 0 matches any funct field.
   task automatic decode_model(input logic [31:0] w);
      e_cls = K_ILL;
      e_alu = 15;
      e_imm = 1'b0;
      foreach (tbl[i])
         if (tbl[i].op == int'(w[31:26]) && (tbl[i].fn < 0 || tbl[i].fn == int'(w[5:0]))) begin
            e_cls = tbl[i].cls;
            e_alu = tbl[i].alu;
            e_imm = tbl[i].imm;
         end
      e_rmux = (w[31:26] == 6'h00);
      e_dmux = (e_cls != K_LD);
   endtask

   function automatic logic [BL-1:0] lanes_model(input int op, input int lsb);
      logic [BL-1:0] r;
      int n, first;
      n = (op == 'h28) ? 1 : (op == 'h29) ? 2 : (op == 'h2B) ? 4 : 0;
      first = (n == 0) ? 0 : (lsb / n) * n;
      r = '0;
      for (int i = 0; i < n; i++) r[first + i] = 1'b1;
      return r;
   endfunction

   task automatic step(input logic rdy, input int st, input logic req, input logic [BL-1:0] wren,
                       input logic rf, input logic pcw, input logic [2:0] pcc, input logic to);
      @(negedge clk);
      mem_ready = rdy;
      #1;
      check("state", state, st);
      check("mem_req", mem_req, req);
      check("data_mem_wren", data_mem_wren, wren);
      check("reg_file_wren", reg_file_wren, rf);
      check("pc_wren", pc_wren, pcw);
      if (pcw) check("pc_control", pc_control, pcc);
      check("mem_timeout", mem_timeout, to);
      check("illegal_op", illegal_op, exp_ill);
      if (dec_chk) begin
         check("alu_control", alu_control, e_alu);
         check("alu_mux_select", alu_mux_select, e_imm);
         check("rmux_select", reg_file_rmux_select, e_rmux);
         check("dmux_select", reg_file_dmux_select, e_dmux);
      end
   endtask

   // A memory access with 'waits' no-ready cycles; every WL of them earns a
   // timeout cycle (request dropped, mem_ready driven high to show it is ignored).
   task automatic mem_phase(input int st, input int waits, input logic [BL-1:0] ln, input logic fetch);
      int k;
      k = 0;
      for (int i = 0; i < waits; i++) begin
         step(1'b0, st, 1'b1, ln, 1'b0, 1'b0, 3'b000, 1'b0);
         k++;
         if (k == WL) begin
            step(1'b1, st, 1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b1);
            k = 0;
         end
      end
      step(1'b1, st, 1'b1, ln, 1'b0, fetch, 3'b000, 1'b0);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      check("rst_state", state, 0);
      check("rst_wren", data_mem_wren, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_illegal", illegal_op, 0);
      exp_ill = 1'b0;
      dec_chk = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic z,
                            input logic [LW-1:0] lsb, input bit abort);
      logic [BL-1:0] ln;
      logic          pcw;
      logic [2:0]    pcc;
      decode_model(w);
      instr_rdata  = w;
      alu_addr_lsb = lsb;
      alu_zero     = z;
      ln = (e_cls == K_ST) ? lanes_model(int'(w[31:26]), int'(lsb)) : '0;
      dec_chk = 1'b0;
      mem_phase(0, fw, '0, 1'b1);
      dec_chk = 1'b1;
      step(1'($urandom), 1, 1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
      if (e_cls == K_ILL) begin
`ifdef MCU_ILLEGAL_TRAP_EN
         exp_ill = 1'b1;
         repeat (3) step(1'($urandom), 5, 1'b0, '0, 1'b0, 1'b0, 3'b000, 1'b0);
         apply_reset();
         return;
`endif
      end
      pcw = (e_cls == K_J) || (e_cls == K_JR) || (e_cls == K_BEQ && z) || (e_cls == K_BNE && !z);
      pcc = (e_cls == K_J) ? 3'b001 : (e_cls == K_JR) ? 3'b010 : 3'b011;
      step(1'($urandom), 2, 1'b0, '0, 1'b0, pcw, pcc, 1'b0);
      if (e_cls == K_LD || e_cls == K_ST) begin
         if (abort) begin
            step(1'b0, 3, 1'b1, ln, 1'b0, 1'b0, 3'b000, 1'b0);
            apply_reset();
            return;
         end
         mem_phase(3, mw, ln, 1'b0);
      end
      if (e_cls == K_LD || e_cls == K_ALU)
         step(1'($urandom), 4, 1'b0, '0, 1'b1, 1'b0, 3'b000, 1'b0);
      dec_chk = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int idx, fw, mw;
      logic [31:0] w;
      reset_n = 1'b0; instr_rdata = '0; mem_ready = 1'b0; alu_zero = 1'b0; alu_addr_lsb = '0;
      exp_ill = 1'b0; dec_chk = 1'b0;

      add(0, 'h00, K_ALU, 'h8, 0); add(0, 'h02, K_ALU, 'h9, 0); add(0, 'h03, K_ALU, 'hA, 0);
      add(0, 'h08, K_JR, 'hF, 0);  add(0, 'h20, K_ALU, 'hB, 0); add(0, 'h21, K_ALU, 'h2, 0);
      add(0, 'h22, K_ALU, 'hC, 0); add(0, 'h23, K_ALU, 'h6, 0); add(0, 'h24, K_ALU, 'h0, 0);
      add(0, 'h25, K_ALU, 'h1, 0); add(0, 'h26, K_ALU, 'h3, 0); add(0, 'h27, K_ALU, 'h4, 0);
      add(0, 'h2A, K_ALU, 'h7, 0);
      add('h02, -1, K_J, 'hF, 0);  add('h03, -1, K_J, 'hF, 0);
      add('h04, -1, K_BEQ, 'hC, 0); add('h05, -1, K_BNE, 'hC, 0);
      add('h08, -1, K_ALU, 'hB, 1); add('h09, -1, K_ALU, 'h2, 1); add('h0A, -1, K_ALU, 'h7, 1);
      add('h0C, -1, K_ALU, 'h0, 1); add('h0D, -1, K_ALU, 'h1, 1);
      add('h20, -1, K_LD, 'hB, 1); add('h21, -1, K_LD, 'hB, 1); add('h23, -1, K_LD, 'hB, 1);
      add('h24, -1, K_LD, 'hF, 1); add('h25, -1, K_LD, 'hF, 1);
      add('h28, -1, K_ST, 'hB, 1); add('h29, -1, K_ST, 'hB, 1); add('h2B, -1, K_ST, 'hB, 1);

      repeat (2) @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("reset_state", state, 0);
      check("reset_mem_req", mem_req, 0);
      check("reset_wren", data_mem_wren, 0);
      check("reset_rf_wren", reg_file_wren, 0);
      check("reset_pc_wren", pc_wren, 0);
      check("reset_dmux", reg_file_dmux_select, 1);
      check("reset_rmux", reg_file_rmux_select, 0);
      check("reset_alu_mux", alu_mux_select, 0);
      check("reset_alu_control", alu_control, 4'b1111);
      check("reset_pc_control", pc_control, 0);
      check("reset_timeout", mem_timeout, 0);
      check("reset_illegal", illegal_op, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      reset_n = 1'b1;

      run_instr(32'h00221820, 0, 0, 1'b0, 2'd0, 1'b0);              // add
      run_instr({6'h04, 26'h0010002}, 1, 0, 1'b1, 2'd0, 1'b0);      // beq taken
      run_instr({6'h04, 26'h0010002}, 0, 0, 1'b0, 2'd0, 1'b0);      // beq not taken
      run_instr({6'h05, 26'h0010002}, 0, 0, 1'b0, 2'd0, 1'b0);      // bne taken
      run_instr({6'h28, 26'h0}, 0, 1, 1'b0, 2'd2, 1'b0);            // sb lane 2
      run_instr({6'h29, 26'h0}, 0, 0, 1'b0, 2'd3, 1'b0);            // sh upper half
      run_instr({6'h2B, 26'h0}, 0, 2, 1'b0, 2'd1, 1'b0);            // sw
      run_instr({6'h23, 26'h0}, 0, 16, 1'b0, 2'd0, 1'b0);           // lw, MEM timeout
      run_instr(32'h00221820, 17, 0, 1'b0, 2'd0, 1'b0);             // fetch timeout
      run_instr({6'h3F, 26'h0}, 0, 0, 1'b0, 2'd0, 1'b0);            // undecoded
      run_instr({6'h2B, 26'h0}, 0, 5, 1'b0, 2'd0, 1'b1);            // reset during sw MEM

      for (int n = 0; n < 200; n++) begin
         idx = $urandom_range(0, tbl.size() + 1);
         w = $urandom;
         if (idx < tbl.size()) begin
            w[31:26] = 6'(tbl[idx].op);
            if (tbl[idx].fn >= 0) w[5:0] = 6'(tbl[idx].fn);
         end else begin
            w[31:26] = (idx == tbl.size()) ? 6'h3F : 6'h30;
         end
         fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2);
         mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2);
         run_instr(w, fw, mw, 1'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
